// File: rtl/fp_exception_stage_pkg.sv
// Shared definitions for the FP exception stage: op encodings, exception codes,
// sticky-flag bit positions, operand class record and the code-priority helper.
package fp_exception_stage_pkg;

    typedef enum logic [1:0] {
        ADDITION       = 2'd0,
        SUBTRACTION    = 2'd1,
        MULTIPLICATION = 2'd2,
        DIVISION       = 2'd3
    } fp_op_e;

    typedef enum logic [2:0] {
        NONE    = 3'd0,
        sNAN    = 3'd1,
        qNAN    = 3'd2,
        INVALID = 3'd3,
        DIVZERO = 3'd4,
        DENORM  = 3'd5
    } exc_code_e;

    localparam int FLAG_SNAN    = 0;
    localparam int FLAG_QNAN    = 1;
    localparam int FLAG_INVALID = 2;
    localparam int FLAG_DIVZERO = 3;
    localparam int FLAG_DENORM  = 4;
    localparam int FLAG_W       = 5;

    typedef struct packed {
        logic is_snan;
        logic is_qnan;
        logic is_inf;
        logic is_zero;
        logic is_denorm;
        logic sign;
    } fp_class_t;

    // Priority-ordered exception selection; the first matching rule wins.
    function automatic exc_code_e exc_code(input fp_op_e op, input fp_class_t a, input fp_class_t b);
        exc_code_e code;
        logic      invalid;
        invalid = 1'b0;
        case (op)
            ADDITION:       invalid = a.is_inf && b.is_inf && (a.sign != b.sign);
            SUBTRACTION:    invalid = a.is_inf && b.is_inf && (a.sign == b.sign);
            MULTIPLICATION: invalid = (a.is_zero && b.is_inf) || (a.is_inf && b.is_zero);
            DIVISION:       invalid = (a.is_zero && b.is_zero) || (a.is_inf && b.is_inf);
            default:        invalid = 1'b0;
        endcase
        if (a.is_snan || b.is_snan) begin
            code = sNAN;
        end else if (a.is_qnan || b.is_qnan) begin
            code = qNAN;
        end else if (invalid) begin
            code = INVALID;
        end else if ((op == DIVISION) && b.is_zero && !a.is_zero && !a.is_inf) begin
            code = DIVZERO;
        end else if (a.is_denorm || b.is_denorm) begin
            code = DENORM;
        end else begin
            code = NONE;
        end
        return code;
    endfunction

    // One-hot sticky-flag contribution of an exception code; NONE contributes nothing.
    function automatic logic [FLAG_W-1:0] code_flag(input exc_code_e code);
        logic [FLAG_W-1:0] f;
        f = '0;
        case (code)
            sNAN:    f[FLAG_SNAN]    = 1'b1;
            qNAN:    f[FLAG_QNAN]    = 1'b1;
            INVALID: f[FLAG_INVALID] = 1'b1;
            DIVZERO: f[FLAG_DIVZERO] = 1'b1;
            DENORM:  f[FLAG_DENORM]  = 1'b1;
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/fp_exception_stage_classify.sv
// fp_classify: combinational IEEE-754 operand classifier for a {sign, exp, man}
// operand of width 1+EXP_W+MAN_W.
module fp_classify
    import fp_exception_stage_pkg::*;
#(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3
) (
    input  logic [EXP_W+MAN_W:0] x,
    output logic                 is_snan,
    output logic                 is_qnan,
    output logic                 is_inf,
    output logic                 is_zero,
    output logic                 is_denorm,
    output logic                 sign
);

    logic exp_ones;
    logic exp_zero;
    logic man_zero;
    logic is_nan;

    assign exp_ones  = &x[EXP_W+MAN_W-1:MAN_W];
    assign exp_zero  = ~|x[EXP_W+MAN_W-1:MAN_W];
    assign man_zero  = ~|x[MAN_W-1:0];
    assign is_nan    = exp_ones && !man_zero;

    // Quiet vs signalling is decided by the mantissa MSB.
    assign is_snan   = is_nan && !x[MAN_W-1];
    assign is_qnan   = is_nan && x[MAN_W-1];
    assign is_inf    = exp_ones && man_zero;
    assign is_zero   = exp_zero && man_zero;
    assign is_denorm = exp_zero && !man_zero;
    assign sign      = x[EXP_W+MAN_W];

endmodule

// File: rtl/fp_exception_stage.sv
// fp_exception_stage: two-stage valid/ready FP exception checker with default results.
// Optional sticky status flags are built when FP_EXCE_STICKY_EN is defined.
module fp_exception_stage
    import fp_exception_stage_pkg::*;
#(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_op,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [1:0]             out_op,
    output logic [EXP_W+MAN_W:0]   out_a,
    output logic [EXP_W+MAN_W:0]   out_b,
    output logic                   out_exc,
    output logic [2:0]             out_code,
    output logic                   out_ovr,
    output logic [EXP_W+MAN_W:0]   out_res,
    input  logic                   flag_clr,
    output logic [FLAG_W-1:0]      flags
);

    localparam int W = 1 + EXP_W + MAN_W;
    localparam logic [W-1:0] CANON_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-1:0] INF_MAG    = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

    logic a_snan_s, a_qnan_s, a_inf_s, a_zero_s, a_denorm_s, a_sign_s;
    logic b_snan_s, b_qnan_s, b_inf_s, b_zero_s, b_denorm_s, b_sign_s;
    fp_class_t cls_a_s;
    fp_class_t cls_b_s;

    logic          s1_valid_r;
    logic [1:0]    s1_op_r;
    logic [W-1:0]  s1_a_r;
    logic [W-1:0]  s1_b_r;
    fp_class_t     s1_cls_a_r;
    fp_class_t     s1_cls_b_r;

    logic          s2_load_s;
    exc_code_e     code_s;
    logic          ovr_s;
    logic [W-1:0]  res_s;

    logic          out_valid_r;
    logic [1:0]    out_op_r;
    logic [W-1:0]  out_a_r;
    logic [W-1:0]  out_b_r;
    logic          out_exc_r;
    exc_code_e     out_code_r;
    logic          out_ovr_r;
    logic [W-1:0]  out_res_r;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_classify_a (
        .x         (in_a),
        .is_snan   (a_snan_s),
        .is_qnan   (a_qnan_s),
        .is_inf    (a_inf_s),
        .is_zero   (a_zero_s),
        .is_denorm (a_denorm_s),
        .sign      (a_sign_s)
    );

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_classify_b (
        .x         (in_b),
        .is_snan   (b_snan_s),
        .is_qnan   (b_qnan_s),
        .is_inf    (b_inf_s),
        .is_zero   (b_zero_s),
        .is_denorm (b_denorm_s),
        .sign      (b_sign_s)
    );

    assign cls_a_s = '{a_snan_s, a_qnan_s, a_inf_s, a_zero_s, a_denorm_s, a_sign_s};
    assign cls_b_s = '{b_snan_s, b_qnan_s, b_inf_s, b_zero_s, b_denorm_s, b_sign_s};

    // Stage 2 advances when empty or draining; in_ready follows out_ready combinationally.
    assign s2_load_s = !out_valid_r || out_ready;
    assign in_ready  = !s1_valid_r || s2_load_s;

    // Stage 1: capture request and operand classes.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= 2'd0;
            s1_a_r     <= '0;
            s1_b_r     <= '0;
            s1_cls_a_r <= '0;
            s1_cls_b_r <= '0;
        end else if (in_ready) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_op_r    <= in_op;
                s1_a_r     <= in_a;
                s1_b_r     <= in_b;
                s1_cls_a_r <= cls_a_s;
                s1_cls_b_r <= cls_b_s;
            end
        end
    end

    // Exception code and default-result selection from registered classes.
    always_comb begin
        code_s = exc_code(fp_op_e'(s1_op_r), s1_cls_a_r, s1_cls_b_r);
        ovr_s  = 1'b0;
        res_s  = '0;
        case (code_s)
            sNAN: begin
                ovr_s = 1'b1;
                res_s = CANON_QNAN;
            end
            qNAN: begin
                ovr_s = 1'b1;
                if (s1_cls_a_r.is_qnan) begin
                    res_s = s1_a_r;
                end else begin
                    res_s = s1_b_r;
                end
            end
            INVALID: begin
                ovr_s = 1'b1;
                res_s = CANON_QNAN;
            end
            DIVZERO: begin
                ovr_s = 1'b1;
                res_s = {s1_cls_a_r.sign ^ s1_cls_b_r.sign, INF_MAG[W-2:0]};
            end
            default: begin
                ovr_s = 1'b0;
                res_s = '0;
            end
        endcase
    end

    // Stage 2: output register, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_op_r    <= 2'd0;
            out_a_r     <= '0;
            out_b_r     <= '0;
            out_exc_r   <= 1'b0;
            out_code_r  <= NONE;
            out_ovr_r   <= 1'b0;
            out_res_r   <= '0;
        end else if (s2_load_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_op_r   <= s1_op_r;
                out_a_r    <= s1_a_r;
                out_b_r    <= s1_b_r;
                out_exc_r  <= (code_s != NONE);
                out_code_r <= code_s;
                out_ovr_r  <= ovr_s;
                out_res_r  <= res_s;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_op    = out_op_r;
    assign out_a     = out_a_r;
    assign out_b     = out_b_r;
    assign out_exc   = out_exc_r;
    assign out_code  = out_code_r;
    assign out_ovr   = out_ovr_r;
    assign out_res   = out_res_r;

`ifdef FP_EXCE_STICKY_EN
    logic [FLAG_W-1:0] flags_r;
    logic [FLAG_W-1:0] flag_set_s;

    // Flag bit contributed by the result leaving the stage this cycle.
    always_comb begin
        flag_set_s = '0;
        if (out_valid_r && out_ready) begin
            flag_set_s = code_flag(out_code_r);
        end else begin
            flag_set_s = '0;
        end
    end

    // Sticky accumulation; a coincident clear keeps only the new event.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_r <= '0;
        end else if (flag_clr) begin
            flags_r <= flag_set_s;
        end else begin
            flags_r <= flags_r | flag_set_s;
        end
    end

    assign flags = flags_r;
`else
    logic unused_flag_clr;

    assign unused_flag_clr = flag_clr;
    assign flags           = '0;
`endif

endmodule

// File: tb/tb_fp_exception_stage.sv
// Self-checking bench for fp_exception_stage: directed test-plan cases, backpressure,
// reset, then randomized traffic against a queue-based reference model.
module tb_fp_exception_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [7:0] in_a, in_b;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_op;
    logic [7:0] out_a, out_b;
    logic       out_exc;
    logic [2:0] out_code;
    logic       out_ovr;
    logic [7:0] out_res;
    logic       flag_clr;
    logic [4:0] flags;

`ifdef FP_EXCE_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] code;
        logic       ovr;
        logic [7:0] res;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [4:0] flags_exp;

    fp_exception_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_exc   (out_exc),
        .out_code  (out_code),
        .out_ovr   (out_ovr),
        .out_res   (out_res),
        .flag_clr  (flag_clr),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: decode fields arithmetically and apply the rule table.
    function automatic exp_t ref_model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t r;
        int ea, ma, eb, mb;
        bit a_nan, b_nan, a_sn, b_sn, a_qn, b_qn, a_inf, b_inf, a_z, b_z, a_dn, b_dn, inv;
        ea = (a / 8) % 16; ma = a % 8;
        eb = (b / 8) % 16; mb = b % 8;
        a_nan = (ea == 15) && (ma != 0);  b_nan = (eb == 15) && (mb != 0);
        a_sn  = a_nan && (ma < 4);        b_sn  = b_nan && (mb < 4);
        a_qn  = a_nan && (ma >= 4);       b_qn  = b_nan && (mb >= 4);
        a_inf = (ea == 15) && (ma == 0);  b_inf = (eb == 15) && (mb == 0);
        a_z   = (ea == 0) && (ma == 0);   b_z   = (eb == 0) && (mb == 0);
        a_dn  = (ea == 0) && (ma != 0);   b_dn  = (eb == 0) && (mb != 0);
        inv = (op == 2'd0 && a_inf && b_inf && a[7] != b[7]) ||
              (op == 2'd1 && a_inf && b_inf && a[7] == b[7]) ||
              (op == 2'd2 && ((a_z && b_inf) || (a_inf && b_z))) ||
              (op == 2'd3 && ((a_z && b_z) || (a_inf && b_inf)));
        r.op = op; r.a = a; r.b = b; r.ovr = 1'b1; r.res = 8'h00;
        if (a_sn || b_sn) begin
            r.code = 3'd1; r.res = 8'h7C;
        end else if (a_qn || b_qn) begin
            r.code = 3'd2; r.res = a_qn ? a : b;
        end else if (inv) begin
            r.code = 3'd3; r.res = 8'h7C;
        end else if (op == 2'd3 && b_z && !a_z && !a_inf) begin
            r.code = 3'd4; r.res = (a[7] ^ b[7]) ? 8'hF8 : 8'h78;
        end else if (a_dn || b_dn) begin
            r.code = 3'd5; r.ovr = 1'b0;
        end else begin
            r.code = 3'd0; r.ovr = 1'b0;
        end
        return r;
    endfunction

    // One cycle: check visible outputs, account handshakes, then advance to the next negedge.
    task automatic tick();
        exp_t e;
        logic [4:0] bit_v;
        #1;
        if (rst) begin
            q.delete();
            flags_exp = 5'd0;
        end else begin
            check_eq("flags", flags, flags_exp);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check_eq("spurious_out_valid", out_valid, 1'b0);
                end else begin
                    e = q[0];
                    check_eq("code", out_code, e.code);
                    check_eq("exc", out_exc, e.code != 3'd0);
                    check_eq("ovr", out_ovr, e.ovr);
                    check_eq("res", out_res, e.res);
                    check_eq("pass", {out_op, out_a, out_b}, {e.op, e.a, e.b});
                end
            end
            bit_v = 5'd0;
            if (out_valid && out_ready && q.size() > 0) begin
                if (q[0].code != 3'd0) bit_v = 5'd1 << (q[0].code - 3'd1);
                void'(q.pop_front());
            end
            if (STICKY) flags_exp = flag_clr ? bit_v : (flags_exp | bit_v);
            if (in_valid && in_ready) q.push_back(ref_model(in_op, in_a, in_b));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single request with latency and directed-value checks, then the output handshake.
    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] ecode, input logic [7:0] eres, input logic clr);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b1; flag_clr = 1'b0;
        tick();
        in_valid = 1'b0;
        check_eq("lat1_valid", out_valid, 1'b0);
        tick();
        check_eq("lat2_valid", out_valid, 1'b1);
        check_eq("dir_code", out_code, ecode);
        check_eq("dir_res", out_res, eres);
        flag_clr = clr;
        tick();
        flag_clr = 1'b0;
    endtask

    logic [7:0] pool [12] = '{8'h00, 8'h80, 8'h78, 8'hF8, 8'h79, 8'h7D, 8'h01, 8'h38, 8'hB8, 8'h7A, 8'hFE, 8'h81};

    initial begin
        int acc;
        int k;
        exp_t bp [4];
        rst = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_a = 8'h00; in_b = 8'h00;
        out_ready = 1'b0; flag_clr = 1'b0; flags_exp = 5'd0;
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_outs", {out_code, out_exc, out_ovr, out_res, out_op, out_a, out_b}, 32'd0);
        check_eq("rst_flags", flags, 5'd0);
        @(negedge clk);

        for (int op = 0; op < 4; op++) begin
            send(2'(op), 8'h79, 8'h00, 3'd1, 8'h7C, 1'b0);
            send(2'(op), 8'h00, 8'h79, 3'd1, 8'h7C, 1'b0);
        end
        check_eq("flag_snan", flags[0], STICKY);
        send(2'd0, 8'h78, 8'hF8, 3'd3, 8'h7C, 1'b0);
        send(2'd1, 8'h78, 8'h78, 3'd3, 8'h7C, 1'b0);
        send(2'd2, 8'h00, 8'h78, 3'd3, 8'h7C, 1'b0);
        send(2'd3, 8'h00, 8'h00, 3'd3, 8'h7C, 1'b0);
        send(2'd3, 8'h38, 8'h00, 3'd4, 8'h78, 1'b0);
        send(2'd3, 8'hB8, 8'h00, 3'd4, 8'hF8, 1'b0);
        send(2'd3, 8'h79, 8'h00, 3'd1, 8'h7C, 1'b0);
        send(2'd0, 8'h7D, 8'h01, 3'd2, 8'h7D, 1'b0);
        send(2'd0, 8'h01, 8'h38, 3'd5, 8'h00, 1'b0);
        send(2'd0, 8'h38, 8'h38, 3'd0, 8'h00, 1'b0);
        send(2'd3, 8'h38, 8'h00, 3'd4, 8'h78, 1'b1);
        check_eq("flag_clr_divzero", flags, STICKY ? 5'b01000 : 5'b00000);

        // Backpressure: four requests offered while the consumer stalls.
        bp[0] = ref_model(2'd0, 8'h38, 8'h38);
        bp[1] = ref_model(2'd3, 8'h38, 8'h00);
        bp[2] = ref_model(2'd0, 8'h01, 8'h38);
        bp[3] = ref_model(2'd2, 8'h00, 8'h78);
        acc = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; in_op = bp[acc].op; in_a = bp[acc].a; in_b = bp[acc].b;
            k = q.size();
            tick();
            if (q.size() > k) acc++;
        end
        #1;
        check_eq("bp_accepted", acc, 2);
        check_eq("bp_in_ready_low", in_ready, 1'b0);
        @(negedge clk);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && acc < 4; c++) begin
            in_valid = 1'b1; in_op = bp[acc].op; in_a = bp[acc].a; in_b = bp[acc].b;
            k = q.size();
            tick();
            if (q.size() > k || (out_valid === 1'b0 && q.size() == k && in_ready)) acc = acc;
            if (q.size() > 0 && q[q.size()-1].a == bp[acc].a && q[q.size()-1].op == bp[acc].op &&
                q[q.size()-1].b == bp[acc].b) acc++;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 10 && q.size() > 0; c++) tick();
        check_eq("bp_all_accepted", acc, 4);
        check_eq("bp_drained", q.size(), 0);

        // Random traffic with random backpressure and occasional flag clears.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flag_clr  = ($urandom_range(0, 19) == 0);
            in_op     = 2'($urandom_range(0, 3));
            in_a      = $urandom_range(0, 1) ? pool[$urandom_range(0, 11)] : 8'($urandom);
            in_b      = $urandom_range(0, 1) ? pool[$urandom_range(0, 11)] : 8'($urandom);
            tick();
        end

        // Reset in mid-stream discards everything in flight.
        out_ready = 1'b0; in_valid = 1'b1; flag_clr = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        check_eq("midrst_out_valid", out_valid, 1'b0);
        check_eq("midrst_flags", flags, 5'd0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();

        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) tick();
        check_eq("final_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
